// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and field positions
// used by the coprocessor-0 block and anything that decodes its registers.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int IM_LSB       = 10;
  localparam int IP_LSB       = 10;
  localparam int INT_W        = 6;
  localparam int CAUSE_BD_BIT = 31;
  localparam int EXC_LSB      = 2;
  localparam int EXC_W        = 5;

  // EPC always holds a word address
  function automatic logic [31:0] word_align(input logic [31:0] v);
    return v & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception entry, eret.
// Single-cycle decision: intreq is combinational, state updates at the edge.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT  = 6,
  parameter logic [31:0] PRID_VAL   = 32'h0000_0000,
  parameter bit          EPC_BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [4:0]           addr,
  input  logic [31:0]          wd,
  output logic [31:0]          rd,
  input  logic [31:0]          pc8_m,
  input  logic                 bd,
  input  logic [4:0]           exccode,
  input  logic                 exlclr,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 intreq,
  output logic [31:0]          epc,
  output logic                 exl
);

  localparam logic [INT_W-1:0] HW_MASK = INT_W'((1 << NUM_HWINT) - 1);

  logic [INT_W-1:0] im_q, im_d;
  logic [INT_W-1:0] ip_q, ip_d;
  logic             exl_q, exl_d;
  logic             ie_q, ie_d;
  logic             bd_q, bd_d;
  logic [EXC_W-1:0] exc_q, exc_d;
  logic [31:0]      epc_q, epc_d;

  logic [INT_W-1:0] hw_ext;
  logic             int_pending;
  logic             wr_sr;
  logic             wr_epc;
  logic [31:0]      epc_exc;

  always_comb begin
    hw_ext = '0;
    hw_ext[NUM_HWINT-1:0] = hwint;
  end

  assign int_pending = ie_q & (|(ip_q & im_q));
  assign intreq      = ~exl_q & (int_pending | (exccode != EXC_INT));
  assign wr_sr       = we & ~intreq & (addr == REG_SR);
  assign wr_epc      = we & ~intreq & (addr == REG_EPC);
  // Delay-slot instructions restart at the branch, one word earlier
  assign epc_exc     = word_align(bd ? (pc8_m - 32'd12) : (pc8_m - 32'd8));

  always_comb begin
    im_d  = im_q;
    ip_d  = hw_ext & HW_MASK;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    epc_d = epc_q;
    if (intreq) begin
      exl_d = 1'b1;
      bd_d  = bd;
      exc_d = int_pending ? EXC_INT : exccode;
      epc_d = epc_exc;
    end else begin
      if (wr_sr) begin
        im_d  = wd[IM_LSB +: INT_W] & HW_MASK;
        exl_d = wd[SR_EXL_BIT];
        ie_d  = wd[SR_IE_BIT];
      end
      if (wr_epc) begin
        epc_d = word_align(wd);
      end
      // eret overrides a simultaneous mtc0 to SR for the EXL bit
      if (exlclr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      REG_SR: begin
        rd[IM_LSB +: INT_W] = im_q;
        rd[SR_EXL_BIT]      = exl_q;
        rd[SR_IE_BIT]       = ie_q;
      end
      REG_CAUSE: begin
        rd[CAUSE_BD_BIT]      = bd_q;
        rd[IP_LSB +: INT_W]   = ip_q;
        rd[EXC_LSB +: EXC_W]  = exc_q;
      end
      REG_EPC:  rd = epc_q;
      REG_PRID: rd = PRID_VAL;
      default:  rd = '0;
    endcase
  end

  assign epc = (EPC_BYPASS && we && (addr == REG_EPC)) ? word_align(wd) : epc_q;
  assign exl = exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: a vector table scored at the falling edge
// through an expectation queue, plus hand-written reset and masking sequences.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0001_9300;

  logic        clk;
  logic        clr;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wd;
  logic [31:0] pc8_m;
  logic        bd;
  logic [4:0]  exccode;
  logic        exlclr;
  logic [5:0]  hwint;
  logic [31:0] rd, rd2;
  logic        intreq, intreq2;
  logic [31:0] epc, epc2;
  logic        exl, exl2;

  int total = 0;
  int bad   = 0;

  cp0_unit #(.NUM_HWINT(6), .PRID_VAL(PRID), .EPC_BYPASS(1'b1)) u_dut (
    .clk(clk), .clr(clr), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .pc8_m(pc8_m), .bd(bd), .exccode(exccode), .exlclr(exlclr),
    .hwint(hwint), .intreq(intreq), .epc(epc), .exl(exl)
  );

  cp0_unit #(.NUM_HWINT(2)) u_dut2 (
    .clk(clk), .clr(clr), .we(we), .addr(addr), .wd(wd), .rd(rd2),
    .pc8_m(pc8_m), .bd(bd), .exccode(exccode), .exlclr(exlclr),
    .hwint(hwint[1:0]), .intreq(intreq2), .epc(epc2), .exl(exl2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
    logic        exlclr;
    logic [5:0]  hw;
    logic        x_int;
    logic        x_exl;
    logic [31:0] x_epc;
    logic [31:0] x_rd;
    logic        chk2;
    logic        x_int2;
    logic [31:0] x_rd2;
  } vec_t;

  typedef struct {
    int          idx;
    logic        x_int;
    logic        x_exl;
    logic [31:0] x_epc;
    logic [31:0] x_rd;
    logic        chk2;
    logic        x_int2;
    logic [31:0] x_rd2;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic vec_t v(
    input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
    input logic b, input logic [4:0] ec, input logic ec_clr, input logic [5:0] h,
    input logic xi, input logic xe, input logic [31:0] xp, input logic [31:0] xr,
    input logic c2, input logic xi2, input logic [31:0] xr2);
    vec_t r;
    r.we = w; r.addr = a; r.wd = d; r.pc8 = pc; r.bd = b; r.exc = ec;
    r.exlclr = ec_clr; r.hw = h; r.x_int = xi; r.x_exl = xe; r.x_epc = xp;
    r.x_rd = xr; r.chk2 = c2; r.x_int2 = xi2; r.x_rd2 = xr2;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", nm, idx, act, req);
    end
  endtask

  task automatic drive(input vec_t x);
    we = x.we; addr = x.addr; wd = x.wd; pc8_m = x.pc8; bd = x.bd;
    exccode = x.exc; exlclr = x.exlclr; hwint = x.hw;
  endtask

  task automatic idle();
    we = 1'b0; addr = 5'd0; wd = '0; pc8_m = '0; bd = 1'b0;
    exccode = 5'd0; exlclr = 1'b0; hwint = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("vec %0d: intreq=%b exl=%b epc=%h rd=%h rd2=%h", e.idx, intreq, exl, epc, rd, rd2);
      chk("intreq", e.idx, {31'd0, intreq}, {31'd0, e.x_int});
      chk("exl", e.idx, {31'd0, exl}, {31'd0, e.x_exl});
      chk("epc", e.idx, epc, e.x_epc);
      chk("rd", e.idx, rd, e.x_rd);
      if (e.chk2) begin
        chk("intreq_n2", e.idx, {31'd0, intreq2}, {31'd0, e.x_int2});
        chk("rd_n2", e.idx, rd2, e.x_rd2);
      end
    end
  end

  initial begin
    exp_t e;
    //          we addr wd            pc8        bd exc exlclr hw     int exl epc          rd            chk2 int2 rd2
    vt.push_back(v(1, 12, 32'h0000_FC01, 32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0));
    vt.push_back(v(0, 12, 32'h0,         32'h0,    0, 0,  0, 6'h04, 0, 0, 32'h0,        32'h0000_FC01, 1, 0, 32'h0000_0C01));
    vt.push_back(v(0, 13, 32'h0,         32'h100,  0, 0,  0, 6'h04, 1, 0, 32'h0,        32'h0000_1000, 1, 0, 32'h0));
    vt.push_back(v(0, 14, 32'h0,         32'h0,    0, 0,  0, 6'h04, 0, 1, 32'hF8,       32'hF8,       0, 0, 32'h0));
    vt.push_back(v(0, 12, 32'h0,         32'h0,    0, 0,  0, 6'h04, 0, 1, 32'hF8,       32'h0000_FC03, 0, 0, 32'h0));
    vt.push_back(v(0, 13, 32'h0,         32'h0,    0, 0,  1, 6'h04, 0, 1, 32'hF8,       32'h0000_1000, 0, 0, 32'h0));
    vt.push_back(v(0, 12, 32'h0,         32'h200,  0, 0,  0, 6'h00, 1, 0, 32'hF8,       32'h0000_FC01, 0, 0, 32'h0));
    vt.push_back(v(0, 14, 32'h0,         32'h0,    0, 0,  1, 6'h00, 0, 1, 32'h1F8,      32'h1F8,      0, 0, 32'h0));
    vt.push_back(v(1, 12, 32'h0000_FC00, 32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h1F8,      32'h0000_FC01, 0, 0, 32'h0));
    vt.push_back(v(0, 13, 32'h0,         32'h3010, 1, 12, 0, 6'h00, 1, 0, 32'h1F8,      32'h0,        0, 0, 32'h0));
    vt.push_back(v(0, 13, 32'h0,         32'h0,    0, 0,  0, 6'h00, 0, 1, 32'h3004,     32'h8000_0030, 0, 0, 32'h0));
    vt.push_back(v(0, 14, 32'h0,         32'h0,    0, 0,  1, 6'h00, 0, 1, 32'h3004,     32'h3004,     0, 0, 32'h0));
    vt.push_back(v(1, 14, 32'h1234,      32'h500,  0, 4,  0, 6'h00, 1, 0, 32'h1234,     32'h3004,     0, 0, 32'h0));
    vt.push_back(v(0, 14, 32'h0,         32'h0,    0, 10, 0, 6'h00, 0, 1, 32'h4F8,      32'h4F8,      0, 0, 32'h0));
    vt.push_back(v(0, 13, 32'h0,         32'h0,    0, 0,  1, 6'h00, 0, 1, 32'h4F8,      32'h10,       0, 0, 32'h0));
    vt.push_back(v(1, 14, 32'h3007,      32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h3004,     32'h4F8,      0, 0, 32'h0));
    vt.push_back(v(0, 14, 32'h0,         32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h3004,     32'h3004,     0, 0, 32'h0));
    vt.push_back(v(1, 12, 32'h0000_FC01, 32'h0,    0, 0,  0, 6'h01, 0, 0, 32'h3004,     32'h0000_FC00, 0, 0, 32'h0));
    vt.push_back(v(0, 13, 32'h0,         32'h600,  0, 12, 0, 6'h01, 1, 0, 32'h3004,     32'h410,      0, 0, 32'h0));
    vt.push_back(v(0, 13, 32'h0,         32'h0,    0, 0,  0, 6'h00, 0, 1, 32'h5F8,      32'h400,      0, 0, 32'h0));
    vt.push_back(v(1, 12, 32'h0000_FC03, 32'h0,    0, 0,  1, 6'h00, 0, 1, 32'h5F8,      32'h0000_FC03, 0, 0, 32'h0));
    vt.push_back(v(0, 12, 32'h0,         32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h5F8,      32'h0000_FC01, 0, 0, 32'h0));
    vt.push_back(v(1, 15, 32'hFFFF_FFFF, 32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h5F8,      PRID,         0, 0, 32'h0));
    vt.push_back(v(0, 15, 32'h0,         32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h5F8,      PRID,         0, 0, 32'h0));
    vt.push_back(v(1, 13, 32'hFFFF_FFFF, 32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h5F8,      32'h0,        0, 0, 32'h0));
    vt.push_back(v(0, 13, 32'h0,         32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h5F8,      32'h0,        0, 0, 32'h0));
    vt.push_back(v(0, 3,  32'h0,         32'h0,    0, 0,  0, 6'h00, 0, 0, 32'h5F8,      32'h0,        0, 0, 32'h0));

    clr = 1'b1;
    idle();
    addr = 5'd12;
    #2;
    chk("reset_intreq", -1, {31'd0, intreq}, 32'd0);
    chk("reset_exl", -1, {31'd0, exl}, 32'd0);
    chk("reset_epc", -1, epc, 32'd0);
    chk("reset_sr", -1, rd, 32'd0);
    addr = 5'd15;
    #1 chk("reset_prid", -1, rd, PRID);
    addr = 5'd13;
    #1 chk("reset_cause", -1, rd, 32'd0);
    @(posedge clk);
    #2 clr = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vt[i]);
      e.idx = i; e.x_int = vt[i].x_int; e.x_exl = vt[i].x_exl; e.x_epc = vt[i].x_epc;
      e.x_rd = vt[i].x_rd; e.chk2 = vt[i].chk2; e.x_int2 = vt[i].x_int2; e.x_rd2 = vt[i].x_rd2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 idle();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end

    // Asynchronous clear in the middle of a cycle, then first IP sample
    @(posedge clk);
    #1 addr = 5'd14;
    #1 chk("pre_clr_epc_reg", -1, rd, 32'h5F8);
    clr = 1'b1;
    #1;
    chk("async_clr_epc", -1, epc, 32'd0);
    chk("async_clr_rd_epc", -1, rd, 32'd0);
    addr = 5'd12;
    #1 chk("async_clr_sr", -1, rd, 32'd0);
    addr = 5'd15;
    #1 chk("async_clr_prid", -1, rd, PRID);
    hwint = 6'h01;
    addr = 5'd13;
    #1 clr = 1'b0;
    #1 chk("ip_before_first_edge", -1, rd, 32'd0);
    @(posedge clk);
    #1;
    chk("ip_first_edge", -1, rd, 32'h0000_0400);
    chk("ip_first_edge_intreq", -1, {31'd0, intreq}, 32'd0);

    // IM masks a pending line until the matching line rises
    we = 1'b1; addr = 5'd12; wd = 32'h0000_0801;
    @(posedge clk);
    #1 we = 1'b0; hwint = 6'h02;
    #1 chk("masked_int", -1, {31'd0, intreq}, 32'd0);
    @(posedge clk);
    #1 chk("unmasked_int", -1, {31'd0, intreq}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
